lsu_mem: RTL and testbench
==========================

LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width (legal values 32 or 64).
REQ-002 SHALL have parameter TAG_W, default 40, width of opaque sideband carried from input to output.
REQ-003 SHALL have ports: clk input 1 clock; rst_n input 1 reset. One clock; reset is synchronous and active-low.
REQ-004 SHALL have ports: in_valid input 1 request valid; in_ready output 1 accept; in_addr input 32 byte address; in_ren input 1 load; in_wen input 1 store; in_op input 3 RISC-V funct3 size/sign; in_wdata input XLEN store data; in_tag input TAG_W sideband.
REQ-005 SHALL have ports: mem_req_valid output 1; mem_req_ready input 1; mem_req_addr output 32 XLEN-aligned address; mem_req_we output 1; mem_req_wstrb output XLEN/8; mem_req_wdata output XLEN.
REQ-006 SHALL have ports: mem_rsp_valid input 1; mem_rsp_rdata input XLEN; mem_rsp_err input 1 bus error.
REQ-007 SHALL have ports: out_valid output 1; out_ready input 1; out_addr output 32; out_rdata output XLEN extended load data; out_tag output TAG_W; out_exc output 1; out_exc_code output 4.

Function
REQ-008 SHALL implement states IDLE, REQ, WAIT_RSP, DONE; in_ready = (state==IDLE).
REQ-009 SHALL capture addr/ren/wen/op/wdata/tag on in_valid&in_ready; IDLE->REQ if ren|wen and access legal, else IDLE->DONE.
REQ-010 SHALL hold mem_req_valid=1 in REQ with all mem_req_* stable until mem_req_ready; then REQ->WAIT_RSP.
REQ-011 SHALL ignore mem_rsp_valid outside WAIT_RSP; in WAIT_RSP on mem_rsp_valid register result and go to DONE.
REQ-012 SHALL assert out_valid only in DONE, holding all out_* stable until out_ready; DONE->IDLE on out_ready.
REQ-013 SHALL give minimum latency accept->out_valid of 3 cycles for memory ops (req cycle 1, rsp sampled cycle 2 earliest, out_valid cycle 3) and 1 cycle for non-memory ops.
REQ-014 SHALL use ops: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only); ops B/H/W sign-extend, others zero-extend; unsupported op treated as W.
REQ-015 SHALL drive mem_req_addr = addr with low log2(XLEN/8) bits cleared; wstrb = size mask shifted by addr offset; wdata = store bytes replicated across all lanes.
REQ-016 SHALL select load bytes from mem_rsp_rdata lane given by addr offset before extension.
REQ-017 SHALL pass through ren=wen=0 ops with out_rdata=0, out_exc=0, tag/addr intact.
REQ-018 SHALL, on mem_rsp_err, set out_exc=1, code 5 (load) or 7 (store), out_rdata=0.
REQ-019 SHALL treat ren&wen both set as a store.

Reset
REQ-020 SHALL on rst_n=0 at a clock edge enter IDLE, clear out_valid, mem_req_valid, out_exc, out_exc_code, out_rdata, out_addr, out_tag; in_ready=1 next cycle.
REQ-021 SHALL abandon any in-flight transaction on reset; a late response after reset is ignored.

Configuration
REQ-022 SHALL honour macro LSU_MISALIGN_EXC_EN: when defined, a non-naturally-aligned access issues no bus request, goes IDLE->DONE with out_exc=1, code 4 (load) or 6 (store); when undefined, misalignment is not checked and offset bits beyond the access size are masked to zero (forced alignment).

Verification (XLEN=32)
REQ-023 SHALL pass: load op 000 at 0x80000003, rdata 0x80FF1234 -> out_rdata 0xFFFFFF80, out_exc=0.
REQ-024 SHALL pass: store op 001 wdata 0x1234ABCD at 0x80000002 -> req addr 0x80000000, we=1, wstrb 1100, wdata 0xABCDABCD.
REQ-025 SHALL pass: macro defined, load op 010 at 0x80000001 -> no mem_req_valid, out_valid next cycle, exc=1, code 4; macro undefined -> req addr 0x80000000, wstrb 1111.
REQ-026 SHALL pass: mem_req_ready low 3 cycles then out_ready low 2 cycles -> req fields and out fields stable throughout, in_ready=0 until out handshake.
REQ-027 SHALL pass: store op 010 with mem_rsp_err=1 -> out_exc=1, code 7.
REQ-028 SHALL pass: rst_n low during WAIT_RSP, then mem_rsp_valid -> no out_valid, state IDLE, in_ready=1.

Source files
------------

// File: rtl/lsu_mem.sv
// lsu_mem: single-outstanding load/store unit between the core and a simple bus.
// Define LSU_MISALIGN_EXC_EN to trap misaligned accesses instead of forcing alignment.
module lsu_mem #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_addr,
    input  logic              in_ren,
    input  logic              in_wen,
    input  logic [2:0]        in_op,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [31:0]       mem_req_addr,
    output logic              mem_req_we,
    output logic [XLEN/8-1:0] mem_req_wstrb,
    output logic [XLEN-1:0]   mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    input  logic              mem_rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_addr,
    output logic [XLEN-1:0]   out_rdata,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_exc,
    output logic [3:0]        out_exc_code
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [31:0]       addr_q;
    logic              wen_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   wdata_q;
    logic [TAG_W-1:0]  tag_q;
    logic [2:0]        in_eop;
    logic              trap;
    logic [1:0]        sz;
    logic [OW-1:0]     off;
    logic [NB-1:0]     smask;
    logic [XLEN-1:0]   rep;
    logic [XLEN-1:0]   sh;
    logic [XLEN-1:0]   ld;

    // Ops this XLEN cannot perform fall back to a signed word access.
    function automatic logic [2:0] legal_op(input logic [2:0] op);
        logic ok;
        ok = (op != 3'b111)
            && (XLEN == 64 || op[1:0] != 2'b11)
            && (XLEN == 64 || op != 3'b110);
        return ok ? op : 3'b010;
    endfunction

    assign in_eop = legal_op(in_op);

`ifdef LSU_MISALIGN_EXC_EN
    logic in_mis;
    always_comb begin
        unique case (in_eop[1:0])
            2'd0:    in_mis = 1'b0;
            2'd1:    in_mis = in_addr[0];
            2'd2:    in_mis = |in_addr[1:0];
            default: in_mis = |in_addr[2:0];
        endcase
    end
    assign trap = (in_ren | in_wen) & in_mis;
`else
    assign trap = 1'b0;
`endif

    // Offset bits below the access size are dropped: forced alignment.
    assign sz    = op_q[1:0];
    assign off   = addr_q[OW-1:0] & ~OW'((32'd1 << sz) - 32'd1);
    assign smask = NB'((32'd1 << (32'd1 << sz)) - 32'd1);
    assign sh    = mem_rsp_rdata >> {off, 3'b000};

    always_comb begin
        unique case (sz)
            2'd0:    rep = {NB{wdata_q[7:0]}};
            2'd1:    rep = {(NB/2){wdata_q[15:0]}};
            2'd2:    rep = {(NB/4){wdata_q[31:0]}};
            default: rep = wdata_q;
        endcase
    end

    always_comb begin
        unique case (sz)
            2'd0:    ld = op_q[2] ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
            2'd1:    ld = op_q[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
            2'd2:    ld = op_q[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
            default: ld = sh;
        endcase
    end

    assign mem_req_addr  = {addr_q[31:OW], OW'(0)};
    assign mem_req_we    = wen_q;
    assign mem_req_wstrb = smask << off;
    assign mem_req_wdata = rep;
    assign out_addr      = addr_q;
    assign out_tag       = tag_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nx = ((in_ren | in_wen) && !trap) ? REQ : DONE;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nx = WAIT_RSP;
            end
            WAIT_RSP: if (mem_rsp_valid) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q       <= '0;
            wen_q        <= 1'b0;
            op_q         <= 3'b010;
            wdata_q      <= '0;
            tag_q        <= '0;
            out_rdata    <= '0;
            out_exc      <= 1'b0;
            out_exc_code <= 4'd0;
        end else begin
            if (in_valid && in_ready) begin
                addr_q       <= in_addr;
                wen_q        <= in_wen;
                op_q         <= in_eop;
                wdata_q      <= in_wdata;
                tag_q        <= in_tag;
                out_rdata    <= '0;
                out_exc      <= trap;
                out_exc_code <= trap ? (in_wen ? 4'd6 : 4'd4) : 4'd0;
            end
            if (state == WAIT_RSP && mem_rsp_valid) begin
                out_rdata    <= (mem_rsp_err || wen_q) ? '0 : ld;
                out_exc      <= mem_rsp_err;
                out_exc_code <= mem_rsp_err ? (wen_q ? 4'd7 : 4'd5) : 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem (XLEN=32): byte-level reference model plus literal pins.
// Honours LSU_MISALIGN_EXC_EN the same way the design does.
module tb_lsu_mem;
    localparam int XLEN  = 32;
    localparam int TAG_W = 40;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_addr;
    logic              in_ren;
    logic              in_wen;
    logic [2:0]        in_op;
    logic [XLEN-1:0]   in_wdata;
    logic [TAG_W-1:0]  in_tag;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [31:0]       mem_req_addr;
    logic              mem_req_we;
    logic [XLEN/8-1:0] mem_req_wstrb;
    logic [XLEN-1:0]   mem_req_wdata;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rsp_rdata;
    logic              mem_rsp_err;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_addr;
    logic [XLEN-1:0]   out_rdata;
    logic [TAG_W-1:0]  out_tag;
    logic              out_exc;
    logic [3:0]        out_exc_code;

    always #5 clk = ~clk;

    lsu_mem #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_ren(in_ren), .in_wen(in_wen), .in_op(in_op),
        .in_wdata(in_wdata), .in_tag(in_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .mem_rsp_err(mem_rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_rdata(out_rdata), .out_tag(out_tag),
        .out_exc(out_exc), .out_exc_code(out_exc_code)
    );

    int tests = 0;
    int fails = 0;

    bit               chk_on = 1'b0;
    bit               busy = 1'b0;
    logic             exp_mem;
    logic [31:0]      exp_raddr, exp_wdata, exp_rdata, exp_addr;
    logic [3:0]       exp_strb, exp_code;
    logic             exp_we, exp_exc;
    logic [TAG_W-1:0] exp_tag;

    bit          req_seen;
    int          lat;
    logic [31:0] l_raddr, l_wdata, l_rdata;
    logic [3:0]  l_strb, l_code;
    logic        l_we, l_exc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: everything derived byte by byte from size, offset and sign rules.
    task automatic model(input logic [31:0] a, input logic r, input logic w,
                         input logic [2:0] op, input logic [31:0] wd,
                         input logic [31:0] rd, input logic err,
                         input logic [TAG_W-1:0] tg);
        int eop, n, off;
        bit sgn, mis, trap;
        longint unsigned v, m;
        eop = (op == 3'd3 || op == 3'd6 || op == 3'd7) ? 2 : int'(op);
        n   = 1 << (eop % 4);
        sgn = eop < 3;
        mis = (a % n) != 0;
        off = ((a % 4) / n) * n;
`ifdef LSU_MISALIGN_EXC_EN
        trap = mis;
`else
        trap = 1'b0;
`endif
        exp_addr  = a;
        exp_tag   = tg;
        exp_raddr = a - (a % 4);
        exp_we    = w;
        exp_strb  = 4'(((1 << n) - 1) << off);
        for (int b = 0; b < 4; b++) exp_wdata[b*8 +: 8] = wd[(b % n)*8 +: 8];
        m = (64'd1 << (8 * n)) - 64'd1;
        v = (64'(rd) >> (8 * off)) & m;
        if (sgn && v[8*n-1]) v = v | ~m;
        exp_mem = (r | w) && !trap;
        if (!(r | w)) begin
            exp_exc = 0; exp_code = 0; exp_rdata = 0;
        end else if (trap) begin
            exp_exc = 1; exp_code = w ? 4'd6 : 4'd4; exp_rdata = 0;
        end else if (err) begin
            exp_exc = 1; exp_code = w ? 4'd7 : 4'd5; exp_rdata = 0;
        end else begin
            exp_exc = 0; exp_code = 0; exp_rdata = w ? 32'd0 : v[31:0];
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            if (busy) chk("in_ready_busy", 64'(in_ready), 64'(0));
            if (mem_req_valid) begin
                if (!exp_mem) chk("req_unexpected", 64'(mem_req_valid), 64'(0));
                else begin
                    chk("req_addr", 64'(mem_req_addr), 64'(exp_raddr));
                    chk("req_we", 64'(mem_req_we), 64'(exp_we));
                    chk("req_wstrb", 64'(mem_req_wstrb), 64'(exp_strb));
                    chk("req_wdata", 64'(mem_req_wdata), 64'(exp_wdata));
                end
            end
            if (out_valid) begin
                chk("out_rdata", 64'(out_rdata), 64'(exp_rdata));
                chk("out_exc", 64'(out_exc), 64'(exp_exc));
                chk("out_code", 64'(out_exc_code), 64'(exp_code));
                chk("out_addr", 64'(out_addr), 64'(exp_addr));
                chk("out_tag", 64'(out_tag), 64'(exp_tag));
            end
        end
    end

    task automatic txn(input logic [31:0] a, input logic r, input logic w,
                       input logic [2:0] op, input logic [31:0] wd,
                       input logic [31:0] rd, input logic err,
                       input int rs, input int os);
        logic [TAG_W-1:0] tg;
        int cnt;
        tg = {a[7:0] ^ 8'h5A, a};
        model(a, r, w, op, wd, rd, err, tg);
        req_seen = 0;
        chk_on   = 1;
        chk("in_ready_idle", 64'(in_ready), 64'(1));
        in_valid = 1; in_addr = a; in_ren = r; in_wen = w;
        in_op = op; in_wdata = wd; in_tag = tg;
        @(posedge clk); #1;
        in_valid = 0;
        busy = 1;
        cnt = 0;
        if (exp_mem) begin
            while (!mem_req_valid && cnt < 8) begin @(posedge clk); #1; cnt++; end
            chk("req_valid", 64'(mem_req_valid), 64'(1));
            req_seen = 1;
            l_raddr = mem_req_addr; l_we = mem_req_we;
            l_strb = mem_req_wstrb; l_wdata = mem_req_wdata;
            repeat (rs) begin @(posedge clk); #1; cnt++; end
            mem_req_ready = 1;
            @(posedge clk); #1; cnt++;
            mem_req_ready = 0;
            mem_rsp_valid = 1; mem_rsp_rdata = rd; mem_rsp_err = err;
            @(posedge clk); #1; cnt++;
            mem_rsp_valid = 0; mem_rsp_err = 0; mem_rsp_rdata = '0;
        end
        while (!out_valid && cnt < 32) begin @(posedge clk); #1; cnt++; end
        chk("out_valid", 64'(out_valid), 64'(1));
        lat = cnt;
        chk("latency", 64'(lat), exp_mem ? 64'(2 + rs) : 64'(0));
        l_rdata = out_rdata; l_exc = out_exc; l_code = out_exc_code;
        repeat (os) begin @(posedge clk); #1; end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        busy = 0;
        chk("in_ready_after", 64'(in_ready), 64'(1));
    endtask

    typedef struct {
        logic [31:0] a;
        logic        r, w;
        logic [2:0]  op;
        logic [31:0] wd, rd;
        logic        err;
        int          rs, os;
    } vec_t;

    vec_t vecs [16] = '{
        '{32'h80000003, 1, 0, 3'd0, 32'h0,        32'h80FF1234, 0, 0, 0},
        '{32'h80000002, 0, 1, 3'd1, 32'h1234ABCD, 32'h0,        0, 0, 0},
        '{32'h80000001, 1, 0, 3'd2, 32'h0,        32'h11223344, 0, 0, 0},
        '{32'h10000002, 1, 0, 3'd4, 32'h0,        32'h80FF1234, 0, 0, 0},
        '{32'h10000002, 1, 0, 3'd1, 32'h0,        32'h80FF1234, 0, 0, 0},
        '{32'h10000000, 1, 0, 3'd5, 32'h0,        32'h80FF8234, 0, 1, 0},
        '{32'h10000004, 1, 0, 3'd2, 32'h0,        32'hDEADBEEF, 0, 0, 1},
        '{32'h20000001, 0, 1, 3'd0, 32'h000000A5, 32'h0,        0, 0, 0},
        '{32'h20000000, 0, 1, 3'd2, 32'hCAFEF00D, 32'h0,        1, 0, 0},
        '{32'h20000008, 1, 0, 3'd2, 32'h0,        32'h12345678, 1, 0, 0},
        '{32'h12345678, 0, 0, 3'd2, 32'hFFFFFFFF, 32'h0,        0, 0, 0},
        '{32'h30000003, 1, 1, 3'd0, 32'h0000003C, 32'h55555555, 0, 0, 0},
        '{32'h40000000, 1, 0, 3'd3, 32'h0,        32'h80000001, 0, 0, 0},
        '{32'h40000004, 1, 0, 3'd6, 32'h0,        32'h90000002, 0, 0, 0},
        '{32'h40000008, 1, 0, 3'd7, 32'h0,        32'hA0000003, 0, 0, 0},
        '{32'h50000002, 1, 0, 3'd1, 32'h0,        32'h7FFF0000, 0, 3, 2}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; in_valid = 0; in_addr = 0; in_ren = 0; in_wen = 0;
        in_op = 0; in_wdata = 0; in_tag = 0; mem_req_ready = 0;
        mem_rsp_valid = 0; mem_rsp_rdata = 0; mem_rsp_err = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_out_exc", 64'(out_exc), 64'(0));
        chk("rst_out_code", 64'(out_exc_code), 64'(0));
        chk("rst_out_rdata", 64'(out_rdata), 64'(0));
        chk("rst_out_addr", 64'(out_addr), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            txn(vecs[i].a, vecs[i].r, vecs[i].w, vecs[i].op, vecs[i].wd,
                vecs[i].rd, vecs[i].err, vecs[i].rs, vecs[i].os);
            case (i)
                0: begin
                    chk("lb_sext_rdata", 64'(l_rdata), 64'h0000_0000_FFFF_FF80);
                    chk("lb_sext_exc", 64'(l_exc), 64'(0));
                end
                1: begin
                    chk("sh_addr", 64'(l_raddr), 64'h8000_0000);
                    chk("sh_we", 64'(l_we), 64'(1));
                    chk("sh_strb", 64'(l_strb), 64'hC);
                    chk("sh_wdata", 64'(l_wdata), 64'hABCD_ABCD);
                end
                2: begin
`ifdef LSU_MISALIGN_EXC_EN
                    chk("mis_no_req", 64'(req_seen), 64'(0));
                    chk("mis_exc", 64'(l_exc), 64'(1));
                    chk("mis_code", 64'(l_code), 64'(4));
                    chk("mis_lat", 64'(lat), 64'(0));
`else
                    chk("mis_addr", 64'(l_raddr), 64'h8000_0000);
                    chk("mis_strb", 64'(l_strb), 64'hF);
`endif
                end
                3: chk("lbu_rdata", 64'(l_rdata), 64'h0000_00FF);
                4: chk("lh_rdata", 64'(l_rdata), 64'hFFFF_80FF);
                8: begin
                    chk("sw_err_exc", 64'(l_exc), 64'(1));
                    chk("sw_err_code", 64'(l_code), 64'(7));
                end
                15: chk("stall_lat", 64'(lat), 64'(5));
                default: ;
            endcase
        end

        // Reset while waiting for a response: the late response must be dropped.
        chk_on = 0;
        in_valid = 1; in_addr = 32'h60000000; in_ren = 1; in_wen = 0;
        in_op = 3'd2; in_tag = 40'h1;
        @(posedge clk); #1;
        in_valid = 0; mem_req_ready = 1;
        @(posedge clk); #1;
        mem_req_ready = 0; rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1; mem_rsp_valid = 1; mem_rsp_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_rsp_valid = 0;
        repeat (3) begin
            chk("late_rsp_out_valid", 64'(out_valid), 64'(0));
            chk("late_rsp_req_valid", 64'(mem_req_valid), 64'(0));
            chk("late_rsp_in_ready", 64'(in_ready), 64'(1));
            @(posedge clk); #1;
        end
        txn(32'h60000004, 1, 0, 3'd2, 32'h0, 32'h0BADC0DE, 0, 0, 0);
        chk("post_rst_rdata", 64'(l_rdata), 64'h0BAD_C0DE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
